// File: rtl/sap1_pkg.sv
// Shared SAP-1 controller definitions: opcodes, T-state names and the control-word layout.
// CTRL_VARCYCLE_EN (see controller_sequencer) needs nothing extra from this package.
package sap1_pkg;

    localparam int SAP_OP_W   = 4;
    localparam int SAP_RING_W = 6;

    localparam logic [SAP_OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [SAP_OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [SAP_OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [SAP_OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [SAP_OP_W-1:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        T_BAD
    } t_state_e;

    typedef struct packed {
        logic cp;
        logic ep;
        logic n_lm;
        logic n_ce;
        logic n_li;
        logic n_ei;
        logic n_la;
        logic ea;
        logic su;
        logic eu;
        logic n_lb;
        logic n_lo;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '{
        cp:   1'b0,
        ep:   1'b0,
        n_lm: 1'b1,
        n_ce: 1'b1,
        n_li: 1'b1,
        n_ei: 1'b1,
        n_la: 1'b1,
        ea:   1'b0,
        su:   1'b0,
        eu:   1'b0,
        n_lb: 1'b1,
        n_lo: 1'b1
    };

    // A ring that is not exactly one-hot maps to T_BAD, which decodes as an idle word.
    function automatic t_state_e ring_to_state(input logic [SAP_RING_W-1:0] ring);
        t_state_e s;
        case (ring)
            6'b000001: s = T1;
            6'b000010: s = T2;
            6'b000100: s = T3;
            6'b001000: s = T4;
            6'b010000: s = T5;
            6'b100000: s = T6;
            default:   s = T_BAD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot T-state ring for the SAP-1 sequencer; steps on the falling clock edge.
// Hold freezes the current state, load_t1 jumps back to T1 ahead of the normal wrap.
module ring_counter #(
    parameter int RING_W = 6
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              hold,
    input  logic              load_t1,
    output logic [RING_W-1:0] ring
);

    generate
        if (RING_W != 6) begin : g_bad_ring_w
            $error("ring_counter: RING_W must be 6");
        end
    endgenerate

    // Falling-edge stepping leaves a full half period before the rising-edge loads elsewhere.
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            ring <= RING_W'(1);
        end else if (load_t1) begin
            ring <= RING_W'(1);
        end else if (!hold) begin
            ring <= {ring[RING_W-2:0], ring[RING_W-1]};
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: opcode latch, halt flag and the control-word decoder.
// Define CTRL_VARCYCLE_EN to end each instruction after its last useful T-state.
module controller_sequencer
    import sap1_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int RING_W = 6
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [OP_W-1:0]   OPCODE,
    output logic              Cp,
    output logic              Ep,
    output logic              nLm,
    output logic              nCE,
    output logic              nLi,
    output logic              nEi,
    output logic              nLa,
    output logic              Ea,
    output logic              Su,
    output logic              Eu,
    output logic              nLb,
    output logic              nLo,
    output logic              HLT,
    output logic [RING_W-1:0] T
);

    logic [RING_W-1:0] ring;
    logic [OP_W-1:0]   op_reg;
    logic              halt;
    logic              load_t1;
    t_state_e          state;
    ctrl_word_t        cw;

    ring_counter #(
        .RING_W (RING_W)
    ) u_ring (
        .clk     (CLK),
        .clr     (CLR),
        .hold    (halt),
        .load_t1 (load_t1),
        .ring    (ring)
    );

    assign state = ring_to_state(ring);

    // The opcode is sampled on the T3->T4 edge only, so later OPCODE activity cannot disturb T4-T6.
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            op_reg <= '0;
            halt   <= 1'b0;
        end else if (state == T3) begin
            op_reg <= OPCODE;
            halt   <= (OPCODE == OP_HLT);
        end
    end

`ifdef CTRL_VARCYCLE_EN
    always_comb begin
        load_t1 = 1'b0;
        if (!halt) begin
            case (op_reg)
                OP_LDA:         load_t1 = (state == T5);
                OP_ADD, OP_SUB: load_t1 = 1'b0;
                OP_HLT:         load_t1 = 1'b0;
                default:        load_t1 = (state == T4);
            endcase
        end
    end
`else
    always_comb begin
        load_t1 = 1'b0;
    end
`endif

    // CLR forces an idle word even though the ring already sits at T1 during reset.
    always_comb begin
        cw = CTRL_IDLE;
        if (!CLR) begin
            case (state)
                T1: begin
                    cw.ep   = 1'b1;
                    cw.n_lm = 1'b0;
                end
                T2: begin
                    cw.cp = 1'b1;
                end
                T3: begin
                    cw.n_ce = 1'b0;
                    cw.n_li = 1'b0;
                end
                T4: begin
                    case (op_reg)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw.n_lm = 1'b0;
                            cw.n_ei = 1'b0;
                        end
                        OP_OUT: begin
                            cw.ea   = 1'b1;
                            cw.n_lo = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (op_reg)
                        OP_LDA: begin
                            cw.n_ce = 1'b0;
                            cw.n_la = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw.n_ce = 1'b0;
                            cw.n_lb = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (op_reg == OP_ADD || op_reg == OP_SUB) begin
                        cw.eu   = 1'b1;
                        cw.n_la = 1'b0;
                        cw.su   = (op_reg == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    bus_single_driver: assert property (@(posedge CLK) disable iff (CLR)
        $onehot0({cw.ep, ~cw.n_ce, ~cw.n_ei, cw.ea, cw.eu}));

    assign Cp  = cw.cp;
    assign Ep  = cw.ep;
    assign nLm = cw.n_lm;
    assign nCE = cw.n_ce;
    assign nLi = cw.n_li;
    assign nEi = cw.n_ei;
    assign nLa = cw.n_la;
    assign Ea  = cw.ea;
    assign Su  = cw.su;
    assign Eu  = cw.eu;
    assign nLb = cw.n_lb;
    assign nLo = cw.n_lo;
    assign HLT = halt;
    assign T   = ring;

endmodule
